mult_result_disp: RTL and testbench



---
 rtl/mult_disp_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 30 +++
 rtl/mult_result_disp.sv | 118 +++++++++++
 tb/tb_mult_result_disp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_disp_pkg.sv
// Shared types and constants for the multiplier result display stage.
package mult_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned PROD_W     = 8;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

    // Segment patterns, bit order gfedcba, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to 7-segment (gfedcba) decoder with a blanking input.
module seg7_decode
    import mult_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pure lookup; codes 10-15 and blanked digits drive all segments off
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            unique case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/mult_result_disp.sv
// Captures the multiplier product, converts it to BCD with an iterative
// double-dabble engine and scans the three digits onto one 7-segment display.
module mult_result_disp
    import mult_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  prod_in,
    input  logic        prod_valid,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg_out,
    output logic [2:0]  dig_sel
);

    localparam int unsigned    PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

    state_t             state_q, state_d;
    logic [PROD_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [2:0]         dig_sel_q, dig_sel_d;
    logic [6:0]         seg_q, seg_d;

    logic [BCD_W-1:0]   adj;
    logic [3:0]         disp_nib;
    logic               disp_blank;

    // Conversion FSM and double-dabble datapath next-state
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        adj       = dd_adjust(scratch_q);
        unique case (state_q)
            IDLE, DONE: begin
                if (prod_valid) begin
                    shift_d   = prod_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                end else begin
                    state_d   = IDLE;
                end
            end
            CONV: begin
                {scratch_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = {adj[BCD_W-2:0], shift_q[PROD_W-1]};
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running prescaler and digit scanner; segments decode the
    // next-cycle digit select and result so they change together with them
    always_comb begin
        presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        dig_sel_d = (presc_q == PRESC_MAX) ? {dig_sel_q[1:0], dig_sel_q[2]} : dig_sel_q;
        if (dig_sel_d[2]) begin
            disp_nib   = bcd_d[11:8];
            disp_blank = (bcd_d[11:8] == 4'd0);
        end else if (dig_sel_d[1]) begin
            disp_nib   = bcd_d[7:4];
            disp_blank = (bcd_d[11:4] == 8'd0);
        end else begin
            disp_nib   = bcd_d[3:0];
            disp_blank = 1'b0;
        end
    end

    seg7_decode u_seg7_decode (
        .nibble (disp_nib),
        .blank  (disp_blank),
        .seg    (seg_d)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            presc_q   <= '0;
            dig_sel_q <= 3'b001;
            seg_q     <= SEG_0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            presc_q   <= presc_d;
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;
    assign seg_out = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_mult_result_disp.sv
// Scoreboard bench for mult_result_disp: the driver predicts acceptance and
// results from decimal arithmetic, a monitor checks outputs every cycle.
module tb_mult_result_disp;

    localparam int unsigned SCAN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  prod_in = 8'd0;
    logic        prod_valid = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic [6:0]  seg_out;
    logic [2:0]  dig_sel;

    always #5 clk = ~clk;

    mult_result_disp #(.SCAN_DIV(SCAN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel)
    );

    int vectors = 0;
    int miscompares = 0;

    // Rising edges seen since reset was released
    int edge_n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    typedef struct {
        int val;
        int edge_k;
    } exp_t;

    exp_t q[$];
    int free_edge = 0;
    int busy_from = -1;
    int busy_to   = -1;
    int disp      = 0;

    function automatic int to_bcd(int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int seg_of(int d);
        case (d)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            7: return 'h07;
            8: return 'h7F;
            9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_seg(int v, int idx);
        int d2, d1, d0;
        d2 = v / 100;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        if (idx == 2) return (d2 == 0) ? 0 : seg_of(d2);
        if (idx == 1) return (d2 == 0 && d1 == 0) ? 0 : seg_of(d1);
        return seg_of(d0);
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)",
                     name, act, exp, edge_n, $time);
        end
    endtask

    // Drive one cycle of input; if valid, decide acceptance from the model
    task automatic drive(int v, bit val);
        exp_t t;
        int k;
        @(negedge clk);
        prod_in    = v[7:0];
        prod_valid = val;
        if (val && rst_n) begin
            k = edge_n + 1;
            if (k >= free_edge) begin
                t.val    = v;
                t.edge_k = k + 8;
                q.push_back(t);
                busy_from = k;
                busy_to   = k + 7;
                free_edge = k + 9;
            end
        end
    endtask

    task automatic apply(int v);
        drive(v, 1'b1);
        drive(0, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0);
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        prod_valid = 1'b0;
        #1;
        q.delete();
        disp      = 0;
        free_edge = 0;
        busy_from = -1;
        busy_to   = -1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd_out, 0);
        chk("rst_dig_sel", dig_sel, 1);
        chk("rst_seg", seg_out, 'h3F);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every cycle just after the active edge
    int   m_e;
    int   m_idx;
    exp_t m_it;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                m_e = edge_n;
                if (q.size() > 0 && q[0].edge_k == m_e) begin
                    m_it = q.pop_front();
                    disp = m_it.val;
                    chk("done_pulse", done, 1);
                    chk("bcd_result", bcd_out, to_bcd(m_it.val));
                end else begin
                    chk("done_idle", done, 0);
                end
                chk("busy", busy, (m_e >= busy_from && m_e <= busy_to) ? 1 : 0);
                chk("bcd_hold", bcd_out, to_bcd(disp));
                m_idx = (m_e / SCAN) % 3;
                chk("dig_sel", dig_sel, 1 << m_idx);
                chk("seg_out", seg_out, exp_seg(disp, m_idx));
            end
        end
    end

    initial begin
        #2;
        reset_assert();
        repeat (2) @(negedge clk);
        reset_release();
        idle(3);

        // Directed values: typical, full scale, zero, blanking cases
        apply(225); idle(14);
        apply(255); idle(14);
        apply(0);   idle(14);
        apply(7);   idle(14);
        apply(105); idle(14);
        apply(10);  idle(14);

        // A valid arriving mid-conversion is dropped
        apply(99);
        drive(200, 1'b1);
        drive(0, 1'b0);
        idle(14);

        // Second product accepted in the DONE cycle
        apply(7);
        idle(7);
        apply(150);
        idle(14);

        // Level-held valid: re-accepted every 9 cycles
        for (int i = 0; i < 20; i++) drive(42 + i, 1'b1);
        idle(14);

        // Reset after the 4th conversion iteration abandons the result
        apply(225);
        idle(4);
        reset_assert();
        repeat (2) @(negedge clk);
        reset_release();
        idle(16);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
        end
        idle(12);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
